// File: rtl/switch_pkg.sv
// Shared types and constants for the switch ingress path: parser states and
// the 10-bit frame buffer entry.
package switch_pkg;

  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hAA;
  localparam logic [7:0] DEFAULT_EOF_BYTE = 8'h55;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_DA,
    RX_SA,
    RX_LEN,
    RX_PAYLOAD,
    RX_PARITY,
    RX_EOF
  } rx_state_t;

  typedef struct packed {
    logic       eop;
    logic       sop;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/frame_fifo.sv
// Frame buffer with speculative write pointer, commit pointer and read pointer.
// Only bytes below commit_ptr are visible to the first-word-fall-through reader.
module frame_fifo
  import switch_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  fifo_entry_t                 wr_entry,
  input  logic                        commit,
  input  logic                        rollback,
  input  logic                        rd_ready,
  output fifo_entry_t                 rd_entry,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  fifo_entry_t   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;

  // The extra pointer bit separates a full buffer from an empty one.
  assign rd_valid = (rd_ptr != commit_ptr);
  assign rd_entry = mem[rd_ptr[AW-1:0]];
  assign level    = wr_ptr - rd_ptr;

  // NOTE: non-blocking assignments so every pointer update sees pre-edge values,
  // which lets commit capture wr_ptr while a rollback or write is also decided.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (rollback) begin
        wr_ptr <= commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (commit) begin
        commit_ptr <= wr_ptr;
      end
      if (rd_valid && rd_ready) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are meaningful.
  always_ff @(posedge clock) begin
    if (wr_en && !rollback) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

endmodule

// File: rtl/switch_packet_receiver.sv
// Ingress frame parser: checks SOF/DA/SA/LEN/PAYLOAD/PARITY/EOF frames, keeps
// good ones in a commit/rollback buffer and streams them out with sop/eop.
module switch_packet_receiver
  import switch_pkg::*;
#(
  parameter int         FIFO_DEPTH = 64,
  parameter int         MAX_LEN    = 32,
  parameter logic [7:0] SOF_BYTE   = DEFAULT_SOF_BYTE,
  parameter logic [7:0] EOF_BYTE   = DEFAULT_EOF_BYTE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       sw_enable_in,
  output logic       read_out,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_parity,
  output logic       err_eof,
  output logic       err_len,
  output logic       err_ovf
);

  localparam int            PW        = $clog2(FIFO_DEPTH) + 1;
  localparam int            CW        = $clog2(MAX_LEN + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] NEED_P    = PW'(MAX_LEN + 3);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [7:0]    parity_acc;
  logic [7:0]    parity_byte;
  logic          drop_flag;

  logic          wr_en;
  fifo_entry_t   wr_entry;
  logic          commit;
  logic          rollback;
  logic          ev_len;
  logic          ev_ovf;
  logic          ev_eof;
  logic          ev_par;
  fifo_entry_t   rd_entry;
  logic          rd_valid;
  logic [PW-1:0] level;
  logic [PW-1:0] free;

  // Reads in the SOF cycle are not credited, so admission stays conservative.
  assign free = DEPTH_P - level;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    wr_en         = 1'b0;
    wr_entry      = '0;
    wr_entry.data = data_in;
    commit        = 1'b0;
    ev_len        = 1'b0;
    ev_ovf        = 1'b0;
    ev_eof        = 1'b0;
    ev_par        = 1'b0;
    if (sw_enable_in) begin
      case (state)
        RX_DA: begin
          wr_en        = !drop_flag;
          wr_entry.sop = 1'b1;
        end
        RX_SA: wr_en = !drop_flag;
        RX_LEN: begin
          if (data_in > MAX_LEN_B) begin
            ev_len = 1'b1;
          end else begin
            wr_en        = !drop_flag;
            wr_entry.eop = (data_in == 8'd0);
          end
        end
        RX_PAYLOAD: begin
          wr_en        = !drop_flag;
          wr_entry.eop = (cnt == CW'(1));
        end
        RX_EOF: begin
          if (drop_flag) begin
            ev_ovf = 1'b1;
          end else if (data_in != EOF_BYTE) begin
            ev_eof = 1'b1;
          end else if (parity_acc != parity_byte) begin
            ev_par = 1'b1;
          end else begin
            commit = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rollback = ev_len | ev_ovf | ev_eof | ev_par;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      parity_acc  <= '0;
      parity_byte <= '0;
      drop_flag   <= 1'b0;
      read_out    <= 1'b0;
      err_parity  <= 1'b0;
      err_eof     <= 1'b0;
      err_len     <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      read_out   <= commit;
      err_parity <= ev_par;
      err_eof    <= ev_eof;
      err_len    <= ev_len;
      err_ovf    <= ev_ovf;
      if (sw_enable_in) begin
        unique case (state)
          RX_IDLE: begin
            if (data_in == SOF_BYTE) begin
              state      <= RX_DA;
              parity_acc <= '0;
              drop_flag  <= (free < NEED_P);
            end
          end
          RX_DA: begin
            parity_acc <= parity_acc ^ data_in;
            state      <= RX_SA;
          end
          RX_SA: begin
            parity_acc <= parity_acc ^ data_in;
            state      <= RX_LEN;
          end
          RX_LEN: begin
            parity_acc <= parity_acc ^ data_in;
            if (data_in > MAX_LEN_B) begin
              state <= RX_IDLE;
            end else if (data_in == 8'd0) begin
              state <= RX_PARITY;
            end else begin
              cnt   <= CW'(data_in);
              state <= RX_PAYLOAD;
            end
          end
          RX_PAYLOAD: begin
            parity_acc <= parity_acc ^ data_in;
            cnt        <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state <= RX_PARITY;
            end
          end
          RX_PARITY: begin
            parity_byte <= data_in;
            state       <= RX_EOF;
          end
          RX_EOF:  state <= RX_IDLE;
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  frame_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_entry (wr_entry),
    .commit   (commit),
    .rollback (rollback),
    .rd_ready (out_ready),
    .rd_entry (rd_entry),
    .rd_valid (rd_valid),
    .level    (level)
  );

  // Outputs are forced low when nothing is committed so reset reads as all-zero.
  assign out_valid = rd_valid;
  assign out_data  = rd_valid ? rd_entry.data : 8'd0;
  assign out_sop   = rd_valid & rd_entry.sop;
  assign out_eop   = rd_valid & rd_entry.eop;

endmodule

// File: tb/tb_switch_packet_receiver.sv
// Scoreboard bench: a frame-level model predicts output bytes and pulse events;
// an independent monitor compares whatever the receiver presents.
module tb_switch_packet_receiver;

  localparam int         DEPTH   = 64;
  localparam int         MAX_LEN = 32;
  localparam logic [7:0] SOF     = 8'hAA;
  localparam logic [7:0] EOFB    = 8'h55;

  localparam int K_COMMIT = 1;
  localparam int K_PAR    = 2;
  localparam int K_EOF    = 4;
  localparam int K_LEN    = 8;
  localparam int K_OVF    = 16;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int kind;
    int cycle;
  } ev_t;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       sw_enable_in;
  logic       read_out;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_valid;
  logic       out_ready;
  logic       err_parity;
  logic       err_eof;
  logic       err_len;
  logic       err_ovf;

  logic [9:0] exp_q[$];
  ev_t        ev_q[$];
  byte_q_t    empty_q;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cycle_cnt = 0;
  int         popped = 0;
  int         committed_total = 0;
  int         ready_mode = 1;

  switch_packet_receiver #(
    .FIFO_DEPTH(DEPTH),
    .MAX_LEN   (MAX_LEN)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .sw_enable_in(sw_enable_in),
    .read_out    (read_out),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_parity  (err_parity),
    .err_eof     (err_eof),
    .err_len     (err_len),
    .err_ovf     (err_ovf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cycle_cnt++;
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Monitor: consumes expected bytes and pulse events as the receiver shows them.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      logic [4:0] p;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else if (out_ready) begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("out_byte", 32'({out_eop, out_sop, out_data}), 32'(e));
          popped++;
        end
      end
      p = {err_ovf, err_len, err_eof, err_parity, read_out};
      if (p != 5'd0) begin
        if (ev_q.size() == 0) begin
          check("unexpected_pulse", 32'(p), 32'd0);
        end else begin
          ev_t ev;
          ev = ev_q.pop_front();
          check("pulse_kind", 32'(p), 32'(ev.kind));
          check("pulse_cycle", 32'(cycle_cnt), 32'(ev.cycle));
          if (read_out) check("visible_with_read_out", 32'(out_valid), 32'd1);
        end
      end else if (ev_q.size() != 0 && ev_q[0].cycle <= cycle_cnt) begin
        ev_t ev;
        ev = ev_q.pop_front();
        check("missing_pulse", 32'(p), 32'(ev.kind));
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      sw_enable_in = 1'b0;
      data_in      = 8'($urandom);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rand_stall(input int pct);
    int k = 0;
    while (k < 6 && int'($urandom_range(99)) < pct) begin
      idle_cycles(1);
      k++;
    end
  endtask

  task automatic drive(input logic [7:0] b);
    sw_enable_in = 1'b1;
    data_in      = b;
    @(posedge clock);
    #1;
    sw_enable_in = 1'b0;
  endtask

  task automatic garbage(input int n);
    repeat (n) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b == SOF) b = 8'h00;
      drive(b);
    end
  endtask

  // Builds a frame, predicts its fate from the frame rules and the buffer
  // occupancy seen at SOF, drives it, and queues the expected response.
  task automatic send_frame(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len,
                            input byte_q_t pl, input logic [7:0] par_xor,
                            input logic [7:0] eof_b, input int stall_pct, input int stall_idx);
    logic [7:0] fr[$];
    logic [7:0] x;
    int         idx;
    int         kind;
    bit         drop;
    fr = {SOF, da, sa, len};
    if (int'(len) <= MAX_LEN) begin
      for (int i = 0; i < int'(len); i++) fr.push_back(i < pl.size() ? pl[i] : 8'($urandom));
      x = 8'd0;
      for (int i = 1; i < fr.size(); i++) x ^= fr[i];
      fr.push_back(x ^ par_xor);
      fr.push_back(eof_b);
    end
    idx  = fr.size() - 1;
    drop = 1'b0;
    for (int i = 0; i < fr.size(); i++) begin
      rand_stall(stall_pct);
      if (i == stall_idx) idle_cycles(2);
      if (i == 0) drop = (DEPTH - (committed_total - popped)) < (MAX_LEN + 3);
      drive(fr[i]);
      if (i == idx) begin
        if (int'(len) > MAX_LEN) begin
          kind = K_LEN;
        end else begin
          x = 8'd0;
          for (int j = 1; j < fr.size() - 2; j++) x ^= fr[j];
          if (drop) kind = K_OVF;
          else if (fr[idx] != EOFB) kind = K_EOF;
          else if (x != fr[idx-1]) kind = K_PAR;
          else kind = K_COMMIT;
        end
        ev_q.push_back('{kind: kind, cycle: cycle_cnt});
        if (kind == K_COMMIT) begin
          for (int j = 1; j <= fr.size() - 3; j++)
            exp_q.push_back({(j == fr.size() - 3), (j == 1), fr[j]});
          committed_total += fr.size() - 3;
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0) && n < budget) begin
      idle_cycles(1);
      n++;
    end
    check("drain_done", 32'(exp_q.size() + ev_q.size()), 32'd0);
  endtask

  task automatic random_frame();
    logic [7:0] len;
    logic [7:0] px;
    logic [7:0] eb;
    if ($urandom_range(9) == 0) len = 8'(MAX_LEN + 1 + int'($urandom_range(7)));
    else len = 8'($urandom_range(MAX_LEN));
    px = ($urandom_range(9) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
    eb = ($urandom_range(9) == 0) ? 8'h56 ^ 8'($urandom_range(15)) : EOFB;
    send_frame(8'($urandom), 8'($urandom), len, empty_q, px, eb, 20, -1);
  endtask

  initial begin
    byte_q_t pl;
    int      p0;
    pl           = {8'h10, 8'h20};
    reset        = 1'b1;
    sw_enable_in = 1'b0;
    data_in      = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs",
          32'({read_out, out_valid, out_data, out_sop, out_eop, err_parity, err_eof, err_len, err_ovf}),
          32'd0);
    reset = 1'b0;
    idle_cycles(2);

    ready_mode = 1;
    send_frame(8'h01, 8'h02, 8'h02, pl, 8'h00, EOFB, 0, -1);
    wait_drain(100);
    send_frame(8'h01, 8'h02, 8'h02, pl, 8'h00, EOFB, 0, 5);
    wait_drain(100);
    send_frame(8'h01, 8'h02, 8'h02, pl, 8'h01, EOFB, 0, -1);
    wait_drain(100);
    send_frame(8'h01, 8'h02, 8'h02, pl, 8'h00, 8'h56, 0, -1);
    send_frame(8'h01, 8'h02, 8'h02, pl, 8'h00, EOFB, 0, -1);
    wait_drain(100);
    send_frame(8'h01, 8'h02, 8'h21, empty_q, 8'h00, EOFB, 0, -1);
    garbage(6);
    send_frame(8'h03, 8'h04, 8'h00, empty_q, 8'h00, EOFB, 0, -1);
    send_frame(8'h05, 8'h06, 8'd32, empty_q, 8'h00, EOFB, 30, -1);
    wait_drain(200);

    // Stalled consumer: second 32-entry frame finds only 32 free slots.
    ready_mode = 0;
    idle_cycles(2);
    p0 = popped;
    send_frame(8'h11, 8'h22, 8'd29, empty_q, 8'h00, EOFB, 0, -1);
    send_frame(8'h33, 8'h44, 8'd29, empty_q, 8'h00, EOFB, 0, -1);
    idle_cycles(3);
    ready_mode = 1;
    wait_drain(200);
    check("ovf_drain_count", 32'(popped - p0), 32'd32);

    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      garbage(int'($urandom_range(3)));
      random_frame();
    end
    ready_mode = 1;
    wait_drain(1000);

    // Reset in the middle of a frame with a committed frame still buffered.
    ready_mode = 0;
    idle_cycles(2);
    send_frame(8'h0A, 8'h0B, 8'd4, empty_q, 8'h00, EOFB, 0, -1);
    idle_cycles(2);
    drive(SOF);
    drive(8'h12);
    drive(8'h34);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_clears_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    ev_q.delete();
    committed_total = 0;
    popped          = 0;
    idle_cycles(2);
    reset      = 1'b0;
    ready_mode = 1;
    idle_cycles(2);
    send_frame(8'h01, 8'h02, 8'h02, pl, 8'h00, EOFB, 0, -1);
    wait_drain(100);

    idle_cycles(4);
    check("events_consumed", 32'(ev_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
